pll_lock_supervisor: RTL and testbench

//  Parametrised lock supervisor for NUM_PLL on-chip PLLs (eth, sys, ddr). Per channel: drives PLL POWERDOWN,

---
 rtl/pll_sup_pkg.sv | 19 +
 rtl/pll_lock_chan.sv | 165 ++++++++++++++++
 rtl/pll_lock_supervisor.sv | 67 ++++++
 tb/tb_pll_lock_supervisor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared state encoding and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_PD     = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } pll_state_e;

  localparam int unsigned LOSS_W = 8;

  // Retry counter width; a zero-retry build still needs a 1-bit register.
  function automatic int unsigned retry_w(input int unsigned max_retry);
    return (max_retry == 0) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/pll_lock_chan.sv
// One supervised PLL channel: LOCK synchroniser, power-cycle FSM, counters.
// Optional lock-loss counter enabled by PLL_SUPERVISOR_LOSS_CNT_EN.
module pll_lock_chan
  import pll_sup_pkg::*;
#(
  parameter int unsigned PD_CYCLES     = 64,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 13
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic restart_i,
  input  logic lock_i,
  output logic powerdown_o,
  output logic rst_o,
  output logic locked_o,
  output logic fault_o
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
  ,
  output logic [LOSS_W-1:0] loss_cnt_o
`endif
);

  localparam int unsigned RW = retry_w(MAX_RETRY);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] PD_TERM   = CNT_W'(PD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_TERM   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAB_TERM = CNT_W'(STABLE_CYCLES - 1);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [1:0]       sync_q, sync_d;
  logic             powerdown_q, powerdown_d;
  logic             rst_q, rst_d;
  logic             locked_q, locked_d;
  logic             fault_q, fault_d;
  logic             lock_s;
  logic             retry_path;

  assign lock_s = sync_q[1];

  // Next state, counter and retry bookkeeping; outputs decoded from next state.
  always_comb begin
    sync_d     = {sync_q[0], lock_i};
    state_d    = state_q;
    cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    retry_d    = retry_q;
    retry_path = 1'b0;

    case (state_q)
      ST_PD: begin
        if (cnt_q == PD_TERM) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_TERM) begin
          retry_path = 1'b1;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == STAB_TERM) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lock_s) retry_path = 1'b1;
      end
      ST_FAULT: begin
        cnt_d = '0;
        if (restart_i) begin
          state_d = ST_PD;
          retry_d = '0;
        end
      end
      default: begin
        state_d = ST_PD;
        cnt_d   = '0;
      end
    endcase

    if (retry_path) begin
      cnt_d = '0;
      if (retry_q < RW'(MAX_RETRY)) begin
        state_d = ST_PD;
        retry_d = retry_q + RW'(1);
      end else begin
        state_d = ST_FAULT;
      end
    end

    // Disable parks the channel in PD; a faulted channel waits for restart.
    if (!enable_i && (state_q != ST_FAULT)) begin
      state_d = ST_PD;
      cnt_d   = '0;
      retry_d = '0;
    end

    powerdown_d = (state_d == ST_PD) || (state_d == ST_FAULT);
    rst_d       = (state_d != ST_RUN);
    locked_d    = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_PD;
      cnt_q       <= '0;
      retry_q     <= '0;
      sync_q      <= '0;
      powerdown_q <= 1'b1;
      rst_q       <= 1'b1;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      sync_q      <= sync_d;
      powerdown_q <= powerdown_d;
      rst_q       <= rst_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
    end
  end

  assign powerdown_o = powerdown_q;
  assign rst_o       = rst_q;
  assign locked_o    = locked_q;
  assign fault_o     = fault_q;

`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              loss_evt;

  // Counts lock loss out of RUN that takes the retry path; restart does not clear it.
  always_comb begin
    loss_evt = (state_q == ST_RUN) && !lock_s && enable_i;
    loss_d   = loss_q;
    if (loss_evt && (loss_q != '1)) loss_d = loss_q + LOSS_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) loss_q <= '0;
    else       loss_q <= loss_d;
  end

  assign loss_cnt_o = loss_q;
`endif

endmodule

// File: rtl/pll_lock_supervisor.sv
// Lock supervisor for NUM_PLL PLLs: per-channel supervision plus all-locked summary.
// Optional per-channel lock-loss counters enabled by PLL_SUPERVISOR_LOSS_CNT_EN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned NUM_PLL       = 3,
  parameter int unsigned PD_CYCLES     = 64,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 13
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [NUM_PLL-1:0] enable_i,
  input  logic [NUM_PLL-1:0] restart_i,
  input  logic [NUM_PLL-1:0] lock_i,
  output logic [NUM_PLL-1:0] powerdown_o,
  output logic [NUM_PLL-1:0] rst_o,
  output logic [NUM_PLL-1:0] locked_o,
  output logic [NUM_PLL-1:0] fault_o,
  output logic               all_locked_o
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
  ,
  output logic [NUM_PLL*LOSS_W-1:0] loss_cnt_o
`endif
);

  logic all_locked_q, all_locked_d;

  for (genvar g = 0; g < NUM_PLL; g++) begin : g_chan
    pll_lock_chan #(
      .PD_CYCLES    (PD_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES),
      .MAX_RETRY    (MAX_RETRY),
      .CNT_W        (CNT_W)
    ) u_chan (
      .clk_i      (wb_clk_i),
      .rst_i      (wb_rst_i),
      .enable_i   (enable_i[g]),
      .restart_i  (restart_i[g]),
      .lock_i     (lock_i[g]),
      .powerdown_o(powerdown_o[g]),
      .rst_o      (rst_o[g]),
      .locked_o   (locked_o[g]),
      .fault_o    (fault_o[g])
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
      ,
      .loss_cnt_o (loss_cnt_o[g*LOSS_W +: LOSS_W])
`endif
    );
  end

  // Disabled channels are don't-care; no enabled channel means not locked.
  always_comb begin
    all_locked_d = (|enable_i) && (&(locked_o | ~enable_i));
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) all_locked_q <= 1'b0;
    else          all_locked_q <= all_locked_d;
  end

  assign all_locked_o = all_locked_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor (2 channels, short timing parameters).
// Loss-counter checks run only when PLL_SUPERVISOR_LOSS_CNT_EN is defined.
module tb_pll_lock_supervisor;

  localparam int unsigned NP = 2;

  logic          clk = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic [NP-1:0] enable_i = '0;
  logic [NP-1:0] restart_i = '0;
  logic [NP-1:0] lock_i = '0;
  logic [NP-1:0] powerdown_o, rst_o, locked_o, fault_o;
  logic          all_locked_o;
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
  logic [NP*8-1:0] loss_cnt_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .NUM_PLL      (NP),
    .PD_CYCLES    (4),
    .LOCK_TIMEOUT (32),
    .STABLE_CYCLES(8),
    .MAX_RETRY    (2),
    .CNT_W        (6)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (wb_rst_i),
    .enable_i    (enable_i),
    .restart_i   (restart_i),
    .lock_i      (lock_i),
    .powerdown_o (powerdown_o),
    .rst_o       (rst_o),
    .locked_o    (locked_o),
    .fault_o     (fault_o),
    .all_locked_o(all_locked_o)
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
    ,
    .loss_cnt_o  (loss_cnt_o)
`endif
  );

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pd"},   32'(powerdown_o),  32'h3);
    chk({tag, "_rst"},  32'(rst_o),        32'h3);
    chk({tag, "_lck"},  32'(locked_o),     32'h0);
    chk({tag, "_flt"},  32'(fault_o),      32'h0);
    chk({tag, "_all"},  32'(all_locked_o), 32'h0);
  endtask

  // Reset for two edges; edge numbering below restarts at the release point.
  task automatic do_reset();
    wb_rst_i = 1'b1;
    ticks(2);
    chk_reset_vals("reset");
    wb_rst_i = 1'b0;
  endtask

  initial begin
    #1;
    // 1: lock 3 cycles after powerdown falls; release after 2+8+1 cycles
    enable_i = 2'b11;
    do_reset();
    ticks(3);  chk("s1_pd_e3", 32'(powerdown_o), 32'h3);
    ticks(1);  chk("s1_pd_e4", 32'(powerdown_o), 32'h0);
    ticks(3);  lock_i = 2'b11;
    ticks(10); chk("s1_rst_l10", 32'(rst_o), 32'h3);
    ticks(1);  chk("s1_rst_l11", 32'(rst_o), 32'h0);
               chk("s1_lck_l11", 32'(locked_o), 32'h3);
               chk("s1_all_l11", 32'(all_locked_o), 32'h0);
    ticks(1);  chk("s1_all_l12", 32'(all_locked_o), 32'h1);

    // 2: no lock -> three timeouts -> FAULT; restart channel 0 -> RUN
    lock_i = 2'b00;
    do_reset();
    ticks(35); chk("s2_pd_e35", 32'(powerdown_o), 32'h0);
    ticks(1);  chk("s2_pd_e36", 32'(powerdown_o), 32'h3);
    ticks(3);  chk("s2_pd_e39", 32'(powerdown_o), 32'h3);
    ticks(1);  chk("s2_pd_e40", 32'(powerdown_o), 32'h0);
    ticks(31); chk("s2_pd_e71", 32'(powerdown_o), 32'h0);
    ticks(1);  chk("s2_pd_e72", 32'(powerdown_o), 32'h3);
               chk("s2_flt_e72", 32'(fault_o), 32'h0);
    ticks(4);  chk("s2_pd_e76", 32'(powerdown_o), 32'h0);
    ticks(31); chk("s2_flt_e107", 32'(fault_o), 32'h0);
    ticks(1);  chk("s2_flt_e108", 32'(fault_o), 32'h3);
               chk("s2_pd_e108", 32'(powerdown_o), 32'h3);
               chk("s2_rst_e108", 32'(rst_o), 32'h3);
    ticks(5);  chk("s2_flt_hold", 32'(fault_o), 32'h3);
    restart_i = 2'b01;
    lock_i    = 2'b01;
    ticks(1);  restart_i = 2'b00;
               chk("s2_flt_rs1", 32'(fault_o), 32'h2);
               chk("s2_pd_rs1", 32'(powerdown_o), 32'h3);
    ticks(12); chk("s2_rst_rs13", 32'(rst_o), 32'h3);
    ticks(1);  chk("s2_rst_rs14", 32'(rst_o), 32'h2);
               chk("s2_lck_rs14", 32'(locked_o), 32'h1);
               chk("s2_flt_rs14", 32'(fault_o), 32'h2);

    // 3: one-cycle lock drop on channel 0 during STABLE
    lock_i = 2'b11;
    do_reset();
    ticks(7);  lock_i = 2'b10;
    ticks(1);  lock_i = 2'b11;
    ticks(2);  chk("s3_pd_e10", 32'(powerdown_o), 32'h0);
               chk("s3_rst_e10", 32'(rst_o), 32'h3);
    ticks(2);  chk("s3_rst_e12", 32'(rst_o), 32'h3);
    ticks(1);  chk("s3_rst_e13", 32'(rst_o), 32'h1);
               chk("s3_lck_e13", 32'(locked_o), 32'h2);
    ticks(5);  chk("s3_rst_e18", 32'(rst_o), 32'h1);
               chk("s3_pd_e18", 32'(powerdown_o), 32'h0);
    ticks(1);  chk("s3_rst_e19", 32'(rst_o), 32'h0);
               chk("s3_all_e19", 32'(all_locked_o), 32'h0);
    ticks(1);  chk("s3_all_e20", 32'(all_locked_o), 32'h1);

    // 4: restart outside FAULT ignored; lock loss in RUN power-cycles channel 0
    restart_i = 2'b11;
    ticks(1);  restart_i = 2'b00;
               chk("s4_rs_rst", 32'(rst_o), 32'h0);
               chk("s4_rs_flt", 32'(fault_o), 32'h0);
    lock_i = 2'b10;
    ticks(2);  chk("s4_rst_r2", 32'(rst_o), 32'h0);
    ticks(1);  chk("s4_rst_r3", 32'(rst_o), 32'h1);
               chk("s4_lck_r3", 32'(locked_o), 32'h2);
               chk("s4_pd_r3", 32'(powerdown_o), 32'h1);
               chk("s4_all_r3", 32'(all_locked_o), 32'h1);
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
               chk("s4_loss_r3", 32'(loss_cnt_o), 32'h0001);
`endif
    lock_i = 2'b11;
    ticks(1);  chk("s4_all_r4", 32'(all_locked_o), 32'h0);
    ticks(2);  chk("s4_pd_r6", 32'(powerdown_o), 32'h1);
    ticks(1);  chk("s4_pd_r7", 32'(powerdown_o), 32'h0);
    ticks(8);  chk("s4_rst_r15", 32'(rst_o), 32'h1);
    ticks(1);  chk("s4_rst_r16", 32'(rst_o), 32'h0);
    ticks(1);  chk("s4_all_r17", 32'(all_locked_o), 32'h1);
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
    for (int i = 0; i < 299; i++) begin
      lock_i = 2'b10;
      ticks(3);
      lock_i = 2'b11;
      ticks(13);
    end
    chk("s4_sat_lck", 32'(locked_o), 32'h3);
    chk("s4_sat_loss", 32'(loss_cnt_o), 32'h00FF);
`endif

    // 5: channel 1 disabled in STABLE; all_locked follows enabled channels only
    lock_i   = 2'b11;
    enable_i = 2'b11;
    do_reset();
    ticks(7);  enable_i = 2'b01;
    ticks(1);  chk("s5_pd_e8", 32'(powerdown_o), 32'h2);
               chk("s5_rst_e8", 32'(rst_o), 32'h3);
    ticks(5);  chk("s5_lck_e13", 32'(locked_o), 32'h1);
               chk("s5_rst_e13", 32'(rst_o), 32'h2);
               chk("s5_all_e13", 32'(all_locked_o), 32'h0);
    ticks(1);  chk("s5_all_e14", 32'(all_locked_o), 32'h1);
               chk("s5_pd_e14", 32'(powerdown_o), 32'h2);
    enable_i = 2'b00;
    ticks(1);  chk("s5_all_e15", 32'(all_locked_o), 32'h0);
               chk("s5_pd_e15", 32'(powerdown_o), 32'h3);
               chk("s5_lck_e15", 32'(locked_o), 32'h0);

    // 6: reset with channel 0 in RUN and channel 1 in FAULT
    lock_i   = 2'b01;
    enable_i = 2'b11;
    do_reset();
    ticks(13);  chk("s6_lck_e13", 32'(locked_o), 32'h1);
    ticks(95);  chk("s6_flt_e108", 32'(fault_o), 32'h2);
    enable_i = 2'b01;
    ticks(2);   chk("s6_all_e110", 32'(all_locked_o), 32'h1);
                chk("s6_flt_e110", 32'(fault_o), 32'h2);
                chk("s6_pd_e110", 32'(powerdown_o), 32'h2);
    wb_rst_i = 1'b1;
    ticks(1);   chk_reset_vals("s6_rst");
    wb_rst_i = 1'b0;
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
